ram2p_clr: RTL and testbench
============================

# ram2p_clr

Parametrised two-port RAM: one synchronous write port (A), one read port (B), asynchronous read by default. It adds three things a plain two-port RAM lacks: a hardware clear sequencer that sweeps every word to a fixed value after reset or on request, an optional registered read stage, and optional write-to-read forwarding. It is the standard storage primitive for buffers and lookup tables that must start from a known state.

## Interface

- DW, 8, data width in bits
- AW, 7, address width; depth is 2^AW words
- INIT_VAL, 0, DW-bit value written to every word by the clear sweep
- REG_OUT, 0, 0 = asynchronous read; 1 = read data registered on ck

- ck  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous reset, active low
- we  in  1  write enable, active low; sampled on ck
- adr_a  in  AW  write address
- dataIn  in  DW  write data
- adr_b  in  AW  read address
- clr  in  1  clear request, active high, sampled on ck
- busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse: sweep finished
- dataOut  out  DW  read data

## Operation

- FSM states: CLEAR, IDLE. Sweep counter cnt is AW bits wide.
- Reset (rst_n=0): state=CLEAR, cnt=0, busy=1, clr_done=0. If REG_OUT=1, the output register is set to INIT_VAL. The memory array itself is not reset.
- CLEAR, on each edge:
  - mem[cnt] <= INIT_VAL and cnt <= cnt+1.
  - When cnt == 2^AW-1 is written: state <= IDLE, cnt <= 0, clr_done <= 1 for one cycle.
- IDLE: if clr=1, state <= CLEAR and cnt <= 0.
- busy = (state==CLEAR).
- Write: mem[adr_a] <= dataIn on an edge where we=0 and busy=0.
  - Writes are ignored while busy.
  - A write on the same edge that samples clr in IDLE is performed, then overwritten by the sweep.
- clr while busy is ignored. The sweep is not restarted.
- Read, REG_OUT=0: dataOut = busy ? INIT_VAL : mem[adr_b], combinational.
- Read, REG_OUT=1: on each edge, the output register <= the same expression; dataOut = output register.
- Reset mid-sweep aborts the sweep and restarts it from address 0 after release.

## Timing

- Sweep length: exactly 2^AW edges after rst_n rises, or after the edge sampling clr.
  - busy falls, and clr_done pulses, after the edge that writes the last address.
  - Default AW=7: 128 cycles.
- Write latency: a word written on edge N is readable at adr_b:
  - REG_OUT=0: immediately after edge N.
  - REG_OUT=1: on dataOut after edge N+1.
- Read latency: REG_OUT=0, combinational (0 cycles); REG_OUT=1, 1 cycle from adr_b.
- First write accepted: the edge after the one where busy is seen falling. That is edge 2^AW+1 after reset release.
- Address wrap: cnt wraps from 2^AW-1 to 0 only on the transition to IDLE. There is no second pass.

## Configuration

- RAM2P_BYPASS_EN defined: forwarding applies when we=0, busy=0 and adr_a==adr_b.
  - The read path selects dataIn instead of mem[adr_b].
  - REG_OUT=0: new data is visible combinationally in the same cycle, before the write edge.
  - REG_OUT=1: the output register captures dataIn on the write edge.
- RAM2P_BYPASS_EN undefined: a same-address read returns old contents.
  - REG_OUT=0: new data appears after the edge.
  - REG_OUT=1: the register captures the old word; the new word appears one cycle later.

## Test plan

- Reset, defaults, INIT_VAL=8'hA5: hold rst_n=0 for 3 cycles, then release.
  - busy=1 for exactly 128 edges, then clr_done pulses once.
  - A read of every address returns 8'hA5.
- Write then read, REG_OUT=0: write 8'h3C at address 5 (we=0), then read adr_b=5.
  - dataOut=8'h3C immediately after the edge.
  - With REG_OUT=1, dataOut=8'h3C one edge later.
- Writes while busy are ignored: pulse clr, then write 8'hFF to address 9 during the sweep.
  - After busy falls, address 9 reads INIT_VAL.
  - dataOut=INIT_VAL throughout busy.
- Same-address read during write: we=0, adr_a=adr_b=12, address 12 holds 8'h11, dataIn=8'h22.
  - Bypass defined: 8'h22 before the edge.
  - Bypass undefined: 8'h11 before the edge, 8'h22 after.
- Reset mid-sweep, clr during sweep:
  - Assert rst_n=0 at sweep cycle 40, then release: busy lasts a full 128 cycles from release.
  - clr pulsed at cycle 60 does not extend busy beyond 128.

Source files
------------

// File: rtl/ram2p_clr.sv
// Two-port RAM (sync write A, read B) with a power-on/on-demand clear sweep to INIT_VAL.
// Optional registered read (REG_OUT) and write-to-read forwarding when RAM2P_BYPASS_EN is defined.
module ram2p_clr #(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   AW       = 7,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter bit            REG_OUT  = 1'b0
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] adr_a,
  input  logic [DW-1:0] dataIn,
  input  logic [AW-1:0] adr_b,
  input  logic          clr,
  output logic          busy,
  output logic          clr_done,
  output logic [DW-1:0] dataOut
);

  localparam int unsigned   DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = {AW{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_done_q, clr_done_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;

  logic          byp_hit;
  logic [DW-1:0] rd_data;

  // Sweep sequencer: cnt walks 0..2^AW-1 once, then returns to IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  // The sweep owns the single write port; user writes are dropped while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = adr_a;
    mem_wdata = dataIn;
    if (busy) begin
      mem_we    = 1'b1;
      mem_adr   = cnt_q;
      mem_wdata = INIT_VAL;
    end else if (!we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (mem_we) begin
      mem[mem_adr] <= mem_wdata;
    end
  end

`ifdef RAM2P_BYPASS_EN
  assign byp_hit = !we && !busy && (adr_a == adr_b);
`else
  assign byp_hit = 1'b0;
`endif

  always_comb begin
    rd_data = mem[adr_b];
    if (busy) begin
      rd_data = INIT_VAL;
    end else if (byp_hit) begin
      rd_data = dataIn;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [DW-1:0] dout_q;
      always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= INIT_VAL;
        end else begin
          dout_q <= rd_data;
        end
      end
      assign dataOut = dout_q;
    end else begin : g_comb_out
      assign dataOut = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram2p_clr.sv
// Bench for ram2p_clr: combinational-read and registered-read instances share stimulus
// and are compared against an array-based model of the sweep, writes and reads.
module tb_ram2p_clr;

  localparam int unsigned   DW    = 8;
  localparam int unsigned   AW    = 7;
  localparam int unsigned   DEPTH = 1 << AW;
  localparam logic [DW-1:0] IV    = 8'hA5;
`ifdef RAM2P_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          ck     = 1'b0;
  logic          rst_n  = 1'b0;
  logic          we     = 1'b1;
  logic          clr    = 1'b0;
  logic [AW-1:0] adr_a  = '0;
  logic [AW-1:0] adr_b  = '0;
  logic [DW-1:0] dataIn = '0;

  logic          busy0, busy1, done0, done1;
  logic [DW-1:0] dout0, dout1;

  always #5 ck = ~ck;

  ram2p_clr #(.DW(DW), .AW(AW), .INIT_VAL(IV), .REG_OUT(1'b0)) u_dut0 (
    .ck(ck), .rst_n(rst_n), .we(we), .adr_a(adr_a), .dataIn(dataIn),
    .adr_b(adr_b), .clr(clr), .busy(busy0), .clr_done(done0), .dataOut(dout0)
  );

  ram2p_clr #(.DW(DW), .AW(AW), .INIT_VAL(IV), .REG_OUT(1'b1)) u_dut1 (
    .ck(ck), .rst_n(rst_n), .we(we), .adr_a(adr_a), .dataIn(dataIn),
    .adr_b(adr_b), .clr(clr), .busy(busy1), .clr_done(done1), .dataOut(dout1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining sweep edges, memory contents, output register.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_rem  = DEPTH;
  bit            m_done = 1'b0;
  logic [DW-1:0] m_reg  = IV;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read();
    if (m_rem > 0) return IV;
    if (BYP && !we && adr_a == adr_b) return dataIn;
    return m_mem[adr_b];
  endfunction

  task automatic check_outputs();
    chk("busy0", busy0, m_rem > 0);
    chk("busy1", busy1, m_rem > 0);
    chk("done0", done0, m_done);
    chk("done1", done1, m_done);
    chk("dout0", dout0, m_read());
    chk("dout1", dout1, m_reg);
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic [DW-1:0] nr;
    #1 check_outputs();
    @(posedge ck);
    if (rst_n) begin
      nr = m_read();
      m_reg = nr;
      if (m_rem > 0) begin
        m_mem[DEPTH - m_rem] = IV;
        m_rem--;
        m_done = (m_rem == 0);
      end else begin
        m_done = 1'b0;
        if (!we) m_mem[adr_a] = dataIn;
        if (clr) m_rem = DEPTH;
      end
    end
    @(negedge ck);
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    m_rem  = DEPTH;
    m_done = 1'b0;
    m_reg  = IV;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  // Runs a bounded window after a sweep start, counting busy samples and clr_done pulses.
  task automatic measure_sweep(input string tag, input int clr_at);
    int nb, nd;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 140; i++) begin
      clr = (i == clr_at);
      #1;
      if (busy0) nb++;
      if (done0) nd++;
      cycle();
    end
    clr = 1'b0;
    chk({tag, "_busy_len"}, nb, DEPTH);
    chk({tag, "_done_cnt"}, nd, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = IV;
    @(negedge ck);

    // Power-on reset, sweep length, every address reads INIT_VAL
    do_reset(3);
    measure_sweep("por", -1);
    we = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      adr_b = AW'(a);
      cycle();
    end
    #1 chk("all_init", dout0, IV);
    cycle();

    // Write then read
    we = 1'b0; adr_a = 7'd5; dataIn = 8'h3C; adr_b = 7'd5;
    cycle();
    we = 1'b1;
    #1 chk("wr_rd_comb", dout0, 8'h3C);
    cycle();
    #1 chk("wr_rd_reg", dout1, 8'h3C);
    cycle();

    // Writes during a sweep are dropped
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    we = 1'b0; adr_a = 7'd9; dataIn = 8'hFF; adr_b = 7'd9;
    for (int i = 0; i < 20; i++) begin
      #1 chk("busy_dout", dout0, IV);
      cycle();
    end
    we = 1'b1;
    repeat (DEPTH) cycle();
    #1 chk("busy_wr_ignored", dout0, IV);
    cycle();

    // Same-address read during write
    we = 1'b0; adr_a = 7'd12; dataIn = 8'h11; adr_b = 7'd3;
    cycle();
    dataIn = 8'h22; adr_b = 7'd12;
    #1 chk("same_pre", dout0, BYP ? 8'h22 : 8'h11);
    cycle();
    we = 1'b1;
    #1 chk("same_post", dout0, 8'h22);
    cycle();

    // Reset at sweep cycle 40, then clr pulsed at cycle 60 of the restarted sweep
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (40) cycle();
    do_reset(2);
    measure_sweep("rst_mid", 60);

    // Randomised traffic with narrow addresses to force collisions
    for (int i = 0; i < 3000; i++) begin
      we     = 1'($urandom_range(0, 1));
      adr_a  = AW'($urandom_range(0, 15));
      adr_b  = ($urandom_range(0, 3) == 0) ? adr_a : AW'($urandom_range(0, 15));
      dataIn = DW'($urandom);
      clr    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 999) == 0) begin
        clr = 1'b0;
        do_reset(2);
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
